i2c_temp_target: RTL and testbench

I2C_TEMP_TARGET -- requirements
Module: i2c_temp_target

---
 rtl/i2c_pkg.sv | 26 ++
 rtl/i2c_line_cond.sv | 77 +++++++
 rtl/i2c_temp_target.sv | 154 +++++++++++++++
 tb/tb_i2c_temp_target.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_pkg.sv
// Shared definitions for the I2C temperature target: FSM states,
// bit-counter sizing, bus acknowledge levels and the majority helper.
package i2c_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    ADDR_ACK,
    TX_BYTE,
    RX_ACK,
    WAIT_STOP
  } state_t;

  localparam int BIT_CNT_W = 4;

  localparam logic [BIT_CNT_W-1:0] LAST_ADDR_BIT = BIT_CNT_W'(7);
  localparam logic [BIT_CNT_W-1:0] BITS_PER_BYTE = BIT_CNT_W'(8);

  localparam logic ACK  = 1'b0;
  localparam logic NACK = 1'b1;

  function automatic logic majority3(input logic [2:0] s);
    return (s[0] & s[1]) | (s[0] & s[2]) | (s[1] & s[2]);
  endfunction

endpackage

// File: rtl/i2c_line_cond.sv
// Line conditioning for scl/sda: synchronizers, optional glitch filter
// (enabled by defining I2C_TGT_GLITCH_FILTER_EN) and START/STOP/edge
// detection on the conditioned levels.
module i2c_line_cond
  import i2c_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic scl,
  input  logic sda,
  output logic sda_level,
  output logic scl_rise,
  output logic scl_fall,
  output logic start_det,
  output logic stop_det
);

  logic [SYNC_STAGES-1:0] scl_sync;
  logic [SYNC_STAGES-1:0] sda_sync;
  logic                   scl_c;
  logic                   sda_c;
  logic                   scl_prev;
  logic                   sda_prev;

  // Bring the asynchronous bus lines into the clk domain; idle bus reads high
  always_ff @(posedge clk) begin
    if (reset) begin
      scl_sync <= '1;
      sda_sync <= '1;
    end else begin
      scl_sync <= {scl_sync[SYNC_STAGES-2:0], scl};
      sda_sync <= {sda_sync[SYNC_STAGES-2:0], sda};
    end
  end

`ifdef I2C_TGT_GLITCH_FILTER_EN
  logic [2:0] scl_hist;
  logic [2:0] sda_hist;

  // Keep the last three synchronized samples so a single-clk pulse is outvoted
  always_ff @(posedge clk) begin
    if (reset) begin
      scl_hist <= '1;
      sda_hist <= '1;
    end else begin
      scl_hist <= {scl_hist[1:0], scl_sync[SYNC_STAGES-1]};
      sda_hist <= {sda_hist[1:0], sda_sync[SYNC_STAGES-1]};
    end
  end

  assign scl_c = majority3(scl_hist);
  assign sda_c = majority3(sda_hist);
`else
  assign scl_c = scl_sync[SYNC_STAGES-1];
  assign sda_c = sda_sync[SYNC_STAGES-1];
`endif

  // Remember the previous conditioned levels for edge and condition detection
  always_ff @(posedge clk) begin
    if (reset) begin
      scl_prev <= 1'b1;
      sda_prev <= 1'b1;
    end else begin
      scl_prev <= scl_c;
      sda_prev <= sda_c;
    end
  end

  assign sda_level = sda_c;
  assign scl_rise  = ~scl_prev & scl_c;
  assign scl_fall  = scl_prev & ~scl_c;
  assign start_det = scl_prev & scl_c & sda_prev & ~sda_c;
  assign stop_det  = scl_prev & scl_c & ~sda_prev & sda_c;

endmodule

// File: rtl/i2c_temp_target.sv
// Read-only I2C target returning a 16-bit temperature word, high byte
// first, wrapping to the high byte while the initiator keeps ACKing.
// Defining I2C_TGT_GLITCH_FILTER_EN adds a majority glitch filter on the
// conditioned bus lines (see i2c_line_cond).
module i2c_temp_target
  import i2c_pkg::*;
#(
  parameter logic [6:0] DEV_ADDR    = 7'h48,
  parameter int         SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        scl,
  inout  wire         sda,
  input  logic [15:0] temp_in,
  output logic        busy,
  output logic        rd_done
);

  state_t                 state;
  logic [BIT_CNT_W-1:0]   bit_cnt;
  logic [6:0]             shift_reg;
  logic [15:0]            shadow;
  logic                   sda_oe;
  logic                   ack_on;
  logic                   byte_sel;
  logic                   sda_level;
  logic                   scl_rise;
  logic                   scl_fall;
  logic                   start_det;
  logic                   stop_det;
  logic [7:0]             cur_byte;
  logic [2:0]             bit_idx;

  i2c_line_cond #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_line_cond (
    .clk       (clk),
    .reset     (reset),
    .scl       (scl),
    .sda       (sda),
    .sda_level (sda_level),
    .scl_rise  (scl_rise),
    .scl_fall  (scl_fall),
    .start_det (start_det),
    .stop_det  (stop_det)
  );

  // Open-drain: only ever pull low, otherwise let the pull-up win
  assign sda = sda_oe ? 1'b0 : 1'bz;

  assign cur_byte = byte_sel ? shadow[7:0] : shadow[15:8];
  assign bit_idx  = 3'd7 - bit_cnt[2:0];

  // Protocol FSM: START/STOP override everything, otherwise step on scl edges
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      bit_cnt   <= '0;
      shift_reg <= '0;
      shadow    <= '0;
      sda_oe    <= 1'b0;
      ack_on    <= 1'b0;
      byte_sel  <= 1'b0;
      busy      <= 1'b0;
      rd_done   <= 1'b0;
    end else begin
      rd_done <= 1'b0;
      if (start_det) begin
        state   <= ADDR;
        bit_cnt <= '0;
        sda_oe  <= 1'b0;
        ack_on  <= 1'b0;
      end else if (stop_det) begin
        state  <= IDLE;
        sda_oe <= 1'b0;
        ack_on <= 1'b0;
        busy   <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            sda_oe <= 1'b0;
          end
          ADDR: begin
            if (scl_rise) begin
              if (bit_cnt == LAST_ADDR_BIT) begin
                bit_cnt <= '0;
                if (shift_reg == DEV_ADDR && sda_level == 1'b1) begin
                  state  <= ADDR_ACK;
                  ack_on <= 1'b0;
                  busy   <= 1'b1;
                end else begin
                  state <= WAIT_STOP;
                  busy  <= 1'b0;
                end
              end else begin
                shift_reg <= {shift_reg[5:0], sda_level};
                bit_cnt   <= bit_cnt + BIT_CNT_W'(1);
              end
            end
          end
          ADDR_ACK: begin
            if (scl_fall) begin
              if (!ack_on) begin
                sda_oe <= 1'b1;
                ack_on <= 1'b1;
                shadow <= temp_in;
              end else begin
                ack_on   <= 1'b0;
                state    <= TX_BYTE;
                byte_sel <= 1'b0;
                sda_oe   <= ~shadow[15];
                bit_cnt  <= BIT_CNT_W'(1);
              end
            end
          end
          TX_BYTE: begin
            if (scl_fall) begin
              if (bit_cnt == BITS_PER_BYTE) begin
                sda_oe  <= 1'b0;
                state   <= RX_ACK;
                bit_cnt <= '0;
              end else begin
                sda_oe  <= ~cur_byte[bit_idx];
                bit_cnt <= bit_cnt + BIT_CNT_W'(1);
              end
            end
          end
          RX_ACK: begin
            sda_oe <= 1'b0;
            if (scl_rise) begin
              if (sda_level == NACK) begin
                state   <= WAIT_STOP;
                rd_done <= 1'b1;
              end else begin
                state    <= TX_BYTE;
                byte_sel <= ~byte_sel;
                bit_cnt  <= '0;
              end
            end
          end
          WAIT_STOP: begin
            sda_oe <= 1'b0;
          end
          default: begin
            state  <= IDLE;
            sda_oe <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_i2c_temp_target.sv
// Testbench for i2c_temp_target: the bench acts as I2C initiator and
// predicts, per bit slot, whether the target must pull sda low, plus busy
// and the number of rd_done pulses. Define I2C_TGT_GLITCH_FILTER_EN to
// also exercise scl glitch rejection.
module tb_i2c_temp_target;
  import i2c_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        scl;
  logic [15:0] temp_in;
  logic        busy;
  logic        rd_done;
  logic        tb_low;
  wire         sda_bus;

  int          checks = 0;
  int          errors = 0;
  int          rd_cnt = 0;
  int          exp_rd_cnt = 0;
  logic        check_en;
  logic        exp_pull;
  logic        exp_busy;
  logic        rd_prev;
  logic [15:0] snap;
  logic [7:0]  rx_q[$];

  pullup pu_sda (sda_bus);
  assign sda_bus = tb_low ? 1'b0 : 1'bz;

  always #5 clk = ~clk;

  i2c_temp_target #(
    .DEV_ADDR   (7'h48),
    .SYNC_STAGES(2)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .scl     (scl),
    .sda     (sda_bus),
    .temp_in (temp_in),
    .busy    (busy),
    .rd_done (rd_done)
  );

  task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
    end
  endtask

  // Continuous comparison of DUT outputs against the bench's expectations
  initial begin
    rd_prev = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      if (check_en) begin
        if (!tb_low) checkOutput("sda_drive", {31'b0, sda_bus === 1'b0}, {31'b0, exp_pull});
        checkOutput("busy", {31'b0, busy}, {31'b0, exp_busy});
      end
      if (rd_done === 1'b1) begin
        rd_cnt++;
        checkOutput("rd_done_width", {31'b0, rd_prev}, 32'd0);
      end
      rd_prev = rd_done;
    end
  end

  // One bit slot: scl low phase then high phase, 8 clk each
  task automatic applyStimulus(input logic drive_low, input logic dut_low,
                               input logic busy_after, input logic glitch,
                               output logic seen);
    scl = 1'b0;
    check_en = 1'b0;
    repeat (3) @(negedge clk);
    tb_low = drive_low;
    repeat (2) @(negedge clk);
    if (glitch) scl = 1'b1;
    @(negedge clk);
    scl = 1'b0;
    exp_pull = dut_low;
    check_en = 1'b1;
    repeat (2) @(negedge clk);
    scl = 1'b1;
    check_en = 1'b0;
    repeat (4) @(negedge clk);
    seen = sda_bus;
    repeat (2) @(negedge clk);
    exp_busy = busy_after;
    check_en = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic startCond();
    check_en = 1'b0;
    tb_low = 1'b1;
    repeat (8) @(negedge clk);
  endtask

  task automatic stopCond();
    scl = 1'b0;
    check_en = 1'b0;
    repeat (3) @(negedge clk);
    tb_low = 1'b1;
    repeat (3) @(negedge clk);
    exp_pull = 1'b0;
    check_en = 1'b1;
    repeat (2) @(negedge clk);
    scl = 1'b1;
    check_en = 1'b0;
    repeat (4) @(negedge clk);
    tb_low = 1'b0;
    repeat (4) @(negedge clk);
    exp_busy = 1'b0;
    check_en = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic sendAddr(input logic [7:0] addr_byte, input int glitch_slot, output logic match);
    logic seen;
    match = (addr_byte[7:1] == 7'h48) && addr_byte[0];
    for (int i = 0; i < 8; i++)
      applyStimulus(~addr_byte[7-i], 1'b0, (i == 7) ? match : exp_busy, i == glitch_slot, seen);
  endtask

  task automatic readBytes(input int nbytes, input logic [15:0] temp_after);
    logic seen;
    logic [7:0] b;
    logic [7:0] rx;
    temp_in = temp_after;
    for (int k = 0; k < nbytes; k++) begin
      b = (k % 2 == 0) ? snap[15:8] : snap[7:0];
      rx = '0;
      for (int j = 0; j < 8; j++) begin
        applyStimulus(1'b0, ~b[7-j], 1'b1, 1'b0, seen);
        rx = {rx[6:0], seen};
      end
      rx_q.push_back(rx);
      checkOutput("rx_byte", {24'b0, rx}, {24'b0, b});
      if (k == nbytes - 1) begin
        applyStimulus(~NACK, 1'b0, 1'b1, 1'b0, seen);
        exp_rd_cnt++;
      end else begin
        applyStimulus(~ACK, 1'b0, 1'b1, 1'b0, seen);
      end
    end
  endtask

  task automatic doRead(input logic [7:0] addr_byte, input logic [15:0] temp, input int nbytes,
                        input logic [15:0] temp_after, input logic do_start, input int glitch_slot);
    logic match;
    logic seen;
    temp_in = temp;
    if (do_start) startCond();
    sendAddr(addr_byte, glitch_slot, match);
    applyStimulus(1'b0, match, match, 1'b0, seen);
    checkOutput("addr_ack_seen", {31'b0, seen}, {31'b0, match ? ACK : NACK});
    if (match) begin
      snap = temp;
      readBytes(nbytes, temp_after);
    end
    stopCond();
  endtask

  initial begin
    logic seen;
    logic match;
    logic [7:0] b;
    reset = 1'b1;
    scl = 1'b1;
    tb_low = 1'b0;
    temp_in = '0;
    check_en = 1'b0;
    exp_pull = 1'b0;
    exp_busy = 1'b0;
    snap = '0;
    repeat (4) @(negedge clk);
    checkOutput("reset_busy", {31'b0, busy}, 32'd0);
    checkOutput("reset_rd_done", {31'b0, rd_done}, 32'd0);
    checkOutput("reset_sda", {31'b0, sda_bus}, 32'd1);
    reset = 1'b0;
    repeat (4) @(negedge clk);
    check_en = 1'b1;

    $display("[TB] read 0x91, two bytes, temp 0x1A80");
    rx_q.delete();
    doRead(8'h91, 16'h1A80, 2, 16'h1A80, 1'b1, -1);
    checkOutput("lit_first_byte", {24'b0, rx_q[0]}, 32'h1A);
    checkOutput("lit_second_byte", {24'b0, rx_q[1]}, 32'h80);
    checkOutput("lit_rd_pulses", rd_cnt, 32'd1);

    $display("[TB] wrong address 0x93");
    doRead(8'h93, 16'h1111, 1, 16'h1111, 1'b1, -1);
    checkOutput("lit_busy_mismatch", {31'b0, busy}, 32'd0);

    $display("[TB] write request 0x90");
    doRead(8'h90, 16'h2222, 1, 16'h2222, 1'b1, -1);

    $display("[TB] three bytes with wrap, temp changes mid-read");
    rx_q.delete();
    doRead(8'h91, 16'hBEEF, 3, 16'h1234, 1'b1, -1);
    checkOutput("lit_wrap_hi", {24'b0, rx_q[0]}, 32'hBE);
    checkOutput("lit_wrap_lo", {24'b0, rx_q[1]}, 32'hEF);
    checkOutput("lit_wrap_third", {24'b0, rx_q[2]}, 32'hBE);

    $display("[TB] repeated START during first data byte");
    temp_in = 16'h1A80;
    startCond();
    sendAddr(8'h91, -1, match);
    applyStimulus(1'b0, match, match, 1'b0, seen);
    snap = 16'h1A80;
    b = 8'h1A;
    for (int j = 0; j < 5; j++) applyStimulus(1'b0, ~b[7-j], 1'b1, 1'b0, seen);
    startCond();
    rx_q.delete();
    doRead(8'h91, 16'h5AC3, 1, 16'h5AC3, 1'b0, -1);
    checkOutput("lit_restart_byte", {24'b0, rx_q[0]}, 32'h5A);

    $display("[TB] reset while driving the address ACK");
    temp_in = 16'h7777;
    startCond();
    sendAddr(8'h91, -1, match);
    scl = 1'b0;
    check_en = 1'b0;
    repeat (6) @(negedge clk);
    exp_pull = 1'b1;
    check_en = 1'b1;
    @(negedge clk);
    checkOutput("ack_before_reset", {31'b0, sda_bus}, 32'd0);
    reset = 1'b1;
    check_en = 1'b0;
    @(posedge clk);
    #2;
    checkOutput("sda_released_on_reset", {31'b0, sda_bus}, 32'd1);
    checkOutput("busy_on_reset", {31'b0, busy}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    exp_pull = 1'b0;
    exp_busy = 1'b0;
    repeat (3) @(negedge clk);
    check_en = 1'b1;
    scl = 1'b1;
    repeat (8) @(negedge clk);
    stopCond();

`ifdef I2C_TGT_GLITCH_FILTER_EN
    $display("[TB] scl glitch inside address byte");
    rx_q.delete();
    doRead(8'h91, 16'hC3A5, 1, 16'hC3A5, 1'b1, 3);
    checkOutput("lit_glitch_byte", {24'b0, rx_q[0]}, 32'hC3);
`endif

    $display("[TB] final read after reset recovery");
    rx_q.delete();
    doRead(8'h91, 16'h0042, 2, 16'h0042, 1'b1, -1);
    checkOutput("lit_final_lo", {24'b0, rx_q[1]}, 32'h42);

    repeat (4) @(negedge clk);
    checkOutput("rd_done_count", rd_cnt, exp_rd_cnt);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
